// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch read bridge: SRAM-like req/addr_ok/data_ok to an AXI3 AR/R master.
// Single-beat reads, fixed ARID, in-order return, up to MAX_OUTST reads in flight.
module inst_axi_rd_bridge #(
    parameter logic [3:0] ARID      = 4'd0,
    parameter int         MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  axi_arid,
    output logic [31:0] axi_araddr,
    output logic [7:0]  axi_arlen,
    output logic [2:0]  axi_arsize,
    output logic [1:0]  axi_arburst,
    output logic [1:0]  axi_arlock,
    output logic [3:0]  axi_arcache,
    output logic [2:0]  axi_arprot,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [3:0]  axi_rid,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rlast,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic        bridge_err
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ADDR  = 1'b1;
    localparam logic [1:0] MAX_CNT = MAX_OUTST[1:0];

    logic [0:0]  r_state;
    logic [31:0] r_araddr;
    logic [1:0]  r_size;
    logic [1:0]  r_cnt;
    logic        r_err;

    logic        w_addr_ok;
    logic        w_rready;
    logic        w_beat;
    logic        w_id_ok;
    logic        w_data_ok;
    logic        w_err_set;

    // Accept/return decode; gated by resetn so nothing handshakes while reset is asserted.
    always_comb begin
        w_addr_ok = 1'b0;
        w_rready  = 1'b0;
        if (resetn) begin
            w_addr_ok = inst_sram_req & ~inst_sram_wr & (r_state == S_IDLE) & (r_cnt < MAX_CNT);
            w_rready  = (r_cnt != 2'd0);
        end else begin
            w_addr_ok = 1'b0;
            w_rready  = 1'b0;
        end
        w_beat    = axi_rvalid & w_rready;
        w_id_ok   = (axi_rid == ARID);
        w_data_ok = w_beat & w_id_ok;
        w_err_set = (inst_sram_req & inst_sram_wr)
                  | (w_beat & ~w_id_ok)
                  | (w_data_ok & ((axi_rresp != 2'b00) | ~axi_rlast));
    end

    // AR channel FSM: latch the request on accept, hold AR stable until arready.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_araddr <= 32'd0;
            r_size   <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_addr_ok) begin
                        r_state  <= S_ADDR;
                        r_araddr <= inst_sram_addr;
                        r_size   <= inst_sram_size;
                    end
                end
                S_ADDR: begin
                    if (axi_arready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outstanding-read counter: accepted but not yet returned to IF.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= 2'd0;
        end else begin
            case ({w_addr_ok, w_data_ok})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign inst_sram_addr_ok = w_addr_ok;
    assign inst_sram_data_ok = w_data_ok;
    assign inst_sram_rdata   = axi_rdata;
    assign axi_arid          = ARID;
    assign axi_araddr        = r_araddr;
    assign axi_arlen         = 8'd0;
    assign axi_arsize        = {1'b0, r_size};
    assign axi_arburst       = 2'b01;
    assign axi_arlock        = 2'b00;
    assign axi_arcache       = 4'b0000;
    assign axi_arprot        = 3'b000;
    assign axi_arvalid       = (r_state == S_ADDR);
    assign axi_rready        = w_rready;
    assign bridge_err        = r_err;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Bench for inst_axi_rd_bridge: directed vector table, hand sequences, random run vs. queue model.
module tb_inst_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic        addr_ok, data_ok;
    logic [31:0] rdata_o;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdat;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(.ARID(4'd0), .MAX_OUTST(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(sz), .inst_sram_addr(addr),
        .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata_o),
        .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
        .axi_arburst(arburst), .axi_arlock(arlock), .axi_arcache(arcache), .axi_arprot(arprot),
        .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rid(rid), .axi_rdata(rdat), .axi_rresp(rresp), .axi_rlast(rlast),
        .axi_rvalid(rvalid), .axi_rready(rready), .bridge_err(err)
    );

    typedef struct {
        logic rn, req, wr; logic [1:0] sz; logic [31:0] addr;
        logic ardy, rv; logic [3:0] rid; logic [31:0] rdat; logic [1:0] rresp; logic rlast;
        logic e_aok, e_dok, e_arv, e_rrdy, e_err;
    } vec_t;

    function automatic vec_t mk(logic rn_i, logic req_i, logic wr_i, logic [1:0] sz_i, logic [31:0] a_i,
                                logic ardy_i, logic rv_i, logic [3:0] rid_i, logic [31:0] rd_i,
                                logic [1:0] rr_i, logic rl_i,
                                logic aok, logic dok, logic arv, logic rrdy, logic e);
        vec_t v;
        v.rn = rn_i; v.req = req_i; v.wr = wr_i; v.sz = sz_i; v.addr = a_i;
        v.ardy = ardy_i; v.rv = rv_i; v.rid = rid_i; v.rdat = rd_i; v.rresp = rr_i; v.rlast = rl_i;
        v.e_aok = aok; v.e_dok = dok; v.e_arv = arv; v.e_rrdy = rrdy; v.e_err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        resetn = v.rn; req = v.req; wr = v.wr; sz = v.sz; addr = v.addr;
        arready = v.ardy; rvalid = v.rv; rid = v.rid; rdat = v.rdat; rresp = v.rresp; rlast = v.rlast;
    endtask

    // One cycle: drive after negedge, compare before the next posedge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #2;
        check({tag, ".addr_ok"}, {31'd0, addr_ok}, {31'd0, v.e_aok});
        check({tag, ".data_ok"}, {31'd0, data_ok}, {31'd0, v.e_dok});
        check({tag, ".arvalid"}, {31'd0, arvalid}, {31'd0, v.e_arv});
        check({tag, ".rready"},  {31'd0, rready},  {31'd0, v.e_rrdy});
        check({tag, ".err"},     {31'd0, err},     {31'd0, v.e_err});
        if (v.e_dok) check({tag, ".rdata"}, rdata_o, v.rdat);
    endtask

    vec_t tbl[$];
    vec_t v;

    // Queue-based reference state for the random run.
    logic        m_busy;
    logic [31:0] m_addr;
    logic [1:0]  m_size;
    logic [31:0] m_q[$];
    logic        m_err;

    initial begin
        drive(mk(0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        check("reset.arvalid", {31'd0, arvalid}, 32'd0);
        check("reset.araddr",  araddr, 32'd0);
        check("reset.arsize",  {29'd0, arsize}, 32'd0);
        check("reset.err",     {31'd0, err}, 32'd0);
        check("reset.rready",  {31'd0, rready}, 32'd0);
        check("reset.consts",  {arid, arlen, arburst, arlock, arcache, arprot, 9'd0},
                               {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 9'd0});

        // single fetch
        tbl.push_back(mk(1,1,0,2,32'h1c000000,1,0,0,0,0,1, 1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1,0,0,0,0,1,            0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,1,0,32'h02800c0c,0,1, 0,1,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,            0,0,0,0,0));
        // outstanding limit
        tbl.push_back(mk(1,1,0,2,32'h1c000010,1,0,0,0,0,1, 1,0,0,0,0));
        tbl.push_back(mk(1,1,0,2,32'h1c000010,1,0,0,0,0,1, 0,0,1,1,0));
        tbl.push_back(mk(1,1,0,2,32'h1c000010,1,0,0,0,0,1, 1,0,0,1,0));
        tbl.push_back(mk(1,1,0,2,32'h1c000010,1,0,0,0,0,1, 0,0,1,1,0));
        tbl.push_back(mk(1,1,0,2,32'h1c000010,1,0,0,0,0,1, 0,0,0,1,0));
        tbl.push_back(mk(1,1,0,2,32'h1c000010,1,0,0,0,0,1, 0,0,0,1,0));
        tbl.push_back(mk(1,1,0,2,32'h1c000010,1,1,0,32'h11,0,1, 0,1,0,1,0));
        tbl.push_back(mk(1,1,0,2,32'h1c000010,1,0,0,0,0,1, 1,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,1,0,0,0,0,1,            0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,1,0,32'h22,0,1,       0,1,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,1,0,32'h33,0,1,       0,1,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,            0,0,0,0,0));
        // write request error, then reset clears it
        tbl.push_back(mk(1,1,1,2,32'h1c000000,1,0,0,0,0,1, 0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,            0,0,0,0,1));
        tbl.push_back(mk(0,1,0,2,32'h1c000000,0,0,0,0,0,1, 0,0,0,0,1));
        // bad rresp
        tbl.push_back(mk(1,1,0,2,32'h1c000020,0,0,0,0,0,1, 1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1,0,0,0,0,1,            0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,1,0,32'h44,2'b10,1,   0,1,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,            0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,            0,0,0,0,1));
        // wrong rid
        tbl.push_back(mk(1,1,0,2,32'h1c000030,0,0,0,0,0,1, 1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1,0,0,0,0,1,            0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,1,4'h3,32'h55,0,1,    0,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,            0,0,0,1,1));
        tbl.push_back(mk(1,0,0,0,0,0,1,0,32'h66,0,1,       0,1,0,1,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,            0,0,0,0,1));
        // reset mid-flight, stray R beat afterwards
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,            0,0,0,0,1));
        tbl.push_back(mk(1,1,0,2,32'h1c000040,0,0,0,0,0,1, 1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,            0,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,            0,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,1,0,32'h77,0,1,       0,0,0,0,0));
        tbl.push_back(mk(1,1,0,2,32'h1c000050,0,0,0,0,0,1, 1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1,0,0,0,0,1,            0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,1,0,32'h88,0,1,       0,1,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,            0,0,0,0,0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // arready stall: AR fields held for 5 cycles, handshake in cycle 6
        apply(mk(1,1,0,1,32'h1c000100,0,0,0,0,0,1, 1,0,0,0,0), "stall.acc");
        for (int i = 0; i < 5; i++) begin
            apply(mk(1,1,0,2,32'h1c000200,0,0,0,0,0,1, 0,0,1,1,0), $sformatf("stall%0d", i));
            check("stall.araddr", araddr, 32'h1c000100);
            check("stall.arsize", {29'd0, arsize}, 32'd1);
        end
        apply(mk(1,0,0,0,0,1,0,0,0,0,1, 0,0,1,1,0), "stall.hs");
        check("stall.hs.araddr", araddr, 32'h1c000100);
        apply(mk(1,0,0,0,0,0,1,0,32'hcafe,0,1, 0,1,0,1,0), "stall.ret");
        apply(mk(1,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0), "stall.idle");

        // ordering: two reads in flight, data returned in order
        apply(mk(1,1,0,2,32'h1c000000,0,0,0,0,0,1, 1,0,0,0,0), "ord.acc0");
        apply(mk(1,0,0,0,0,1,0,0,0,0,1, 0,0,1,1,0), "ord.hs0");
        check("ord.araddr0", araddr, 32'h1c000000);
        apply(mk(1,1,0,2,32'h1c000004,0,0,0,0,0,1, 1,0,0,1,0), "ord.acc1");
        apply(mk(1,0,0,0,0,1,0,0,0,0,1, 0,0,1,1,0), "ord.hs1");
        check("ord.araddr1", araddr, 32'h1c000004);
        apply(mk(1,0,0,0,0,0,1,0,32'hA,0,1, 0,1,0,1,0), "ord.rA");
        apply(mk(1,0,0,0,0,0,1,0,32'hB,0,1, 0,1,0,1,0), "ord.rB");
        apply(mk(1,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0), "ord.idle");

        // random run against the queue model
        apply(mk(0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0), "rnd.reset");
        m_busy = 1'b0; m_addr = 32'd0; m_size = 2'd0; m_q.delete(); m_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic e_aok, e_rrdy, e_dok, beat;
            @(negedge clk);
            v.rn    = 1'b1;
            v.req   = 1'($urandom_range(0, 1));
            v.wr    = ($urandom_range(0, 31) == 0);
            v.sz    = 2'($urandom_range(0, 2));
            v.addr  = $urandom & 32'hfffffffc;
            v.ardy  = 1'($urandom_range(0, 1));
            v.rv    = 1'($urandom_range(0, 1));
            v.rid   = ($urandom_range(0, 31) == 0) ? 4'h3 : 4'h0;
            v.rdat  = $urandom;
            v.rresp = ($urandom_range(0, 31) == 0) ? 2'b10 : 2'b00;
            v.rlast = ($urandom_range(0, 31) != 0);
            drive(v);
            #2;
            e_aok  = v.req && !v.wr && !m_busy && (m_q.size() < 2);
            e_rrdy = (m_q.size() > 0);
            beat   = v.rv && e_rrdy;
            e_dok  = beat && (v.rid == 4'h0);
            check("rnd.addr_ok", {31'd0, addr_ok}, {31'd0, e_aok});
            check("rnd.data_ok", {31'd0, data_ok}, {31'd0, e_dok});
            check("rnd.rready",  {31'd0, rready},  {31'd0, e_rrdy});
            check("rnd.arvalid", {31'd0, arvalid}, {31'd0, m_busy});
            check("rnd.err",     {31'd0, err},     {31'd0, m_err});
            if (m_busy) begin
                check("rnd.araddr", araddr, m_addr);
                check("rnd.arsize", {29'd0, arsize}, {30'd0, m_size});
            end
            if (e_dok) check("rnd.rdata", rdata_o, v.rdat);
            // state after the coming posedge
            if (m_busy && v.ardy) m_busy = 1'b0;
            if (e_aok) begin
                m_busy = 1'b1; m_addr = v.addr; m_size = v.sz; m_q.push_back(v.addr);
            end
            if (e_dok) void'(m_q.pop_front());
            if ((v.req && v.wr) || (beat && v.rid != 4'h0) ||
                (e_dok && (v.rresp != 2'b00 || !v.rlast))) m_err = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
